// File: rtl/gs_sweep_ctrl.sv
// gs_sweep_ctrl: Gauss-Seidel sequencer (clear, b load, sweeps, ring-aligned drain).
// Optional GS_EARLY_EXIT_EN: conv_in ends SWEEP after a fully converged sweep; iters_used_out reports sweeps run.
module gs_sweep_ctrl #(
  parameter int N = 16,
  parameter int IDX_W = 4,
  parameter int ITER_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [ITER_W-1:0] iters_in,
  input  logic              b_valid_in,
  input  logic [15:0]       b_in,
  output logic              b_ready_out,
  output logic              rf_rst_out,
  output logic              rf_en_out,
  output logic [15:0]       rf_b_out,
  input  logic [31:0]       x_in,
  output logic [IDX_W-1:0]  elem_idx_out,
  output logic              busy_out,
  output logic [31:0]       x_out,
  output logic              x_valid_out,
  input  logic              x_ready_in,
  output logic              done_out,
  output logic              err_out
`ifdef GS_EARLY_EXIT_EN
  ,
  input  logic              conv_in,
  output logic [ITER_W-1:0] iters_used_out
`endif
);
  typedef enum logic [2:0] {IDLE, CLR, LOAD, SWEEP, DRAIN} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] load_cnt, phase, out_idx;
  logic [ITER_W-1:0] iters_q, iter_cnt;
  logic start_ok, beat, load_last, load_break, wrap, last_sweep, accept;
  assign start_ok = state == IDLE && start_in;
  assign beat = state == LOAD && b_valid_in;
  assign load_last = beat && load_cnt == IDX_W'(N - 1);
  assign load_break = state == LOAD && !b_valid_in && load_cnt != '0;
  assign wrap = state == SWEEP && phase == IDX_W'(N - 1);
`ifdef GS_EARLY_EXIT_EN
  logic conv_acc, conv_all;
  // conv_all: every element of the current sweep so far reported converged
  assign conv_all = conv_in && (phase == '0 || conv_acc);
  assign last_sweep = wrap && (iter_cnt + ITER_W'(1) == iters_q || conv_all);
`else
  assign last_sweep = wrap && iter_cnt + ITER_W'(1) == iters_q;
`endif
  assign b_ready_out = state == LOAD;
  assign rf_rst_out = start_ok;
  assign busy_out = state != IDLE;
  assign elem_idx_out = state == SWEEP ? phase : '0;
  assign x_valid_out = state == DRAIN && phase == out_idx;
  assign x_out = x_valid_out ? x_in : '0;
  assign accept = x_valid_out && x_ready_in;
  assign done_out = accept && out_idx == IDX_W'(N - 1);
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = start_in ? CLR : IDLE;
      CLR:   state_nx = LOAD;
      LOAD:  state_nx = load_last ? SWEEP : load_break ? IDLE : LOAD;
      SWEEP: state_nx = last_sweep ? DRAIN : SWEEP;
      DRAIN: state_nx = done_out ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      load_cnt  <= '0;
      phase     <= '0;
      out_idx   <= '0;
      iters_q   <= '0;
      iter_cnt  <= '0;
      rf_en_out <= 1'b0;
      rf_b_out  <= '0;
      err_out   <= 1'b0;
    end else begin
      rf_en_out <= beat;
      if (beat) rf_b_out <= b_in;
      if (start_ok) begin
        iters_q  <= iters_in == '0 ? ITER_W'(1) : iters_in;
        err_out  <= 1'b0;
        load_cnt <= '0;
        phase    <= '0;
        out_idx  <= '0;
        iter_cnt <= '0;
      end
      if (beat) load_cnt <= load_cnt + IDX_W'(1);
      if (load_break) err_out <= 1'b1;
      // phase tracks the free-running ring through SWEEP and DRAIN
      if (state == SWEEP || state == DRAIN) phase <= phase + IDX_W'(1);
      if (wrap) iter_cnt <= iter_cnt + ITER_W'(1);
      if (accept) out_idx <= out_idx + IDX_W'(1);
    end
`ifdef GS_EARLY_EXIT_EN
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      conv_acc       <= 1'b0;
      iters_used_out <= '0;
    end else begin
      if (state == SWEEP) conv_acc <= conv_all;
      if (start_ok) begin
        conv_acc       <= 1'b0;
        iters_used_out <= '0;
      end
      if (last_sweep) iters_used_out <= iter_cnt + ITER_W'(1);
    end
`endif
endmodule

// File: tb/tb_gs_sweep_ctrl.sv
// tb_gs_sweep_ctrl: directed bench with b/x scoreboards for gs_sweep_ctrl.
module tb_gs_sweep_ctrl;
  logic clk_in, rst_in, start_in, b_valid_in, b_ready_out, rf_rst_out, rf_en_out;
  logic busy_out, x_valid_out, x_ready_in, done_out, err_out;
  logic [7:0] iters_in;
  logic [15:0] b_in, rf_b_out;
  logic [31:0] x_in, x_out;
  logic [3:0] elem_idx_out;
  int checks = 0, errors = 0;
  logic [15:0] bq[$];
  logic [31:0] xq[$];
`ifdef GS_EARLY_EXIT_EN
  logic conv_in;
  logic [7:0] iters_used_out;
  int conv_from = 99;
`endif
  gs_sweep_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .iters_in(iters_in),
    .b_valid_in(b_valid_in), .b_in(b_in), .b_ready_out(b_ready_out),
    .rf_rst_out(rf_rst_out), .rf_en_out(rf_en_out), .rf_b_out(rf_b_out),
    .x_in(x_in), .elem_idx_out(elem_idx_out), .busy_out(busy_out),
    .x_out(x_out), .x_valid_out(x_valid_out), .x_ready_in(x_ready_in),
    .done_out(done_out), .err_out(err_out)
`ifdef GS_EARLY_EXIT_EN
    , .conv_in(conv_in), .iters_used_out(iters_used_out)
`endif
  );
  initial begin
    clk_in = 0;
    forever #5 clk_in = ~clk_in;
  end
  function automatic logic [15:0] bpat(input int k);
    return 16'hB00B ^ 16'(k * 16'h1357);
  endfunction
  function automatic logic [31:0] xpat(input int k);
    return 32'h5A00_C300 ^ 32'(k * 32'h0101_0101);
  endfunction
  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clk1();
    @(posedge clk_in);
    #1;
  endtask
  task automatic start_run(input int it);
    clk1();
    start_in = 1;
    iters_in = 8'(it);
    #3;
    ck("rf_rst_pulse", rf_rst_out, 1);
    ck("busy_at_start", busy_out, 0);
    clk1();
    start_in = 0;
    #3;
    ck("clr_busy", busy_out, 1);
    ck("clr_ready", b_ready_out, 0);
    ck("clr_rf_rst", rf_rst_out, 0);
    ck("clr_err", err_out, 0);
  endtask
  task automatic load(input int nb);
    for (int k = 0; k < nb; k++) begin
      clk1();
      b_valid_in = 1;
      b_in = bpat(k);
      bq.push_back(b_in);
      #3;
      ck("load_ready", b_ready_out, 1);
      ck("load_rf_en", rf_en_out, k > 0);
      if (k > 0) ck("rf_b", rf_b_out, bq.pop_front());
    end
  endtask
  task automatic sweep(input int total);
    for (int s = 0; s < total; s++) begin
      clk1();
      b_valid_in = 0;
      start_in = (s == 5);
`ifdef GS_EARLY_EXIT_EN
      conv_in = (s >= conv_from * 16);
`endif
      #3;
      if (s == 0) begin
        ck("sweep_rf_en_last", rf_en_out, 1);
        ck("rf_b_last", rf_b_out, bq.pop_front());
      end
      if (s == 1) ck("sweep_rf_en_off", rf_en_out, 0);
      if (s == 5) ck("start_ignored", rf_rst_out, 0);
      ck("elem_idx", elem_idx_out, s % 16);
      ck("sweep_busy", busy_out, 1);
      ck("sweep_xvalid", x_valid_out, 0);
      ck("sweep_ready", b_ready_out, 0);
    end
    start_in = 0;
  endtask
  task automatic drain(input int miss);
    int p = 0, got = 0, n = 0;
    bit missed = 0;
    logic exp_v, rdy;
    for (int k = 0; k < 16; k++) xq.push_back(xpat(k));
    while (got < 16 && n < 400) begin
      clk1();
      x_in = xpat(p);
      rdy = !(p == miss && got == miss && !missed);
      x_ready_in = rdy;
      #3;
      exp_v = (p == got);
      ck("x_valid", x_valid_out, exp_v);
      ck("drain_busy", busy_out, 1);
      ck("done", done_out, exp_v && rdy && got == 15);
      if (exp_v && rdy) begin
        ck("x_out", x_out, xq.pop_front());
        got++;
      end else if (exp_v) missed = 1;
      p = (p + 1) % 16;
      n++;
    end
    ck("drain_words", got, 16);
    clk1();
    x_ready_in = 0;
    #3;
    ck("post_busy", busy_out, 0);
    ck("post_xvalid", x_valid_out, 0);
    ck("post_done", done_out, 0);
    ck("xq_empty", xq.size(), 0);
  endtask
  initial begin
    rst_in = 1;
    start_in = 0;
    iters_in = 0;
    b_valid_in = 0;
    b_in = 0;
    x_in = 0;
    x_ready_in = 0;
`ifdef GS_EARLY_EXIT_EN
    conv_in = 0;
`endif
    clk1();
    clk1();
    #3;
    ck("rst_busy", busy_out, 0);
    ck("rst_ready", b_ready_out, 0);
    ck("rst_rf_en", rf_en_out, 0);
    ck("rst_rf_b", rf_b_out, 0);
    ck("rst_err", err_out, 0);
    ck("rst_xvalid", x_valid_out, 0);
    ck("rst_elem", elem_idx_out, 0);
    clk1();
    rst_in = 0;
    start_run(3);
    load(5);
    clk1();
    rst_in = 1;
    b_valid_in = 0;
    #3;
    ck("midrst_busy", busy_out, 0);
    ck("midrst_ready", b_ready_out, 0);
    ck("midrst_rf_en", rf_en_out, 0);
    ck("midrst_done", done_out, 0);
    clk1();
    rst_in = 0;
    #3;
    ck("after_rst_busy", busy_out, 0);
    ck("after_rst_rf_rst", rf_rst_out, 0);
    ck("after_rst_done", done_out, 0);
    bq.delete();
    start_run(3);
    load(16);
    sweep(48);
    drain(-1);
    start_run(1);
    load(16);
    sweep(16);
    drain(4);
    start_run(2);
    load(7);
    clk1();
    b_valid_in = 0;
    #3;
    ck("brk_ready", b_ready_out, 1);
    ck("brk_rf_en", rf_en_out, 1);
    ck("brk_rf_b", rf_b_out, bq.pop_front());
    ck("brk_err_pre", err_out, 0);
    clk1();
    #3;
    ck("brk_err", err_out, 1);
    ck("brk_busy", busy_out, 0);
    ck("brk_ready_off", b_ready_out, 0);
    ck("brk_bq_empty", bq.size(), 0);
    start_run(2);
    load(16);
    sweep(32);
    drain(-1);
    start_run(0);
    load(16);
    sweep(16);
    drain(-1);
`ifdef GS_EARLY_EXIT_EN
    conv_from = 1;
    start_run(10);
    load(16);
    sweep(32);
    drain(-1);
    ck("iters_used", iters_used_out, 2);
    conv_from = 99;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
